// File: rtl/im_loader.sv
// Instruction-memory loader: takes 32-bit words over a valid/ready stream and
// writes each one as four big-endian byte writes into the byte-wide IM.
module im_loader #(
  parameter int ADDR_W    = 10,
  parameter int MEM_BYTES = 1024,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SUM_W = ADDR_W + CNT_W + 1;

  typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        idx;
  logic [31:0]       word;
  logic [SUM_W-1:0]  end_addr;
  logic              range_bad;

  // Wide enough that base + 4*count can never wrap.
  assign end_addr  = SUM_W'(base_addr) + (SUM_W'(word_count) << 2);
  assign range_bad = (base_addr[1:0] != 2'b00) || (end_addr > SUM_W'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start) state_d = (range_bad || word_count == '0) ? DONE : WAIT_WORD;
      WAIT_WORD: if (in_valid) state_d = WRITE;
      WRITE:     if (idx == 2'd3) state_d = (remaining == CNT_W'(1)) ? DONE : WAIT_WORD;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state, so they change on the same
  // edge as the state and nothing combinational reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      we        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      ptr       <= '0;
      remaining <= '0;
      idx       <= '0;
      word      <= '0;
    end else begin
      in_ready <= (state_d == WAIT_WORD);
      we       <= (state_d == WRITE);
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      case (state)
        IDLE: if (start) begin
          err <= range_bad;
          if (!range_bad) begin
            ptr       <= base_addr;
            remaining <= word_count;
          end
        end
        WAIT_WORD: if (in_valid) begin
          // Byte 0 goes out next cycle; the rest wait in a left-shifting word.
          wdata <= in_data[31:24];
          word  <= {in_data[23:0], 8'h00};
          waddr <= ptr;
          idx   <= 2'd0;
        end
        WRITE: if (idx != 2'd3) begin
          idx   <= idx + 2'd1;
          waddr <= waddr + ADDR_W'(1);
          wdata <= word[31:24];
          word  <= word << 8;
        end else begin
          ptr       <= ptr + ADDR_W'(4);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected byte writes are queued when a word
// is handed over and retired against the DUT's write port.
module tb_im_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [9:0]  base_addr;
  logic [8:0]  word_count;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready, we, busy, done, err;
  logic [9:0]  waddr;
  logic [7:0]  wdata;

  typedef struct packed {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t         sb[$];
  logic [7:0]  im [0:1023];
  logic [31:0] words [0:7];
  logic [9:0]  tptr;
  int          vectors = 0;
  int          miscompares = 0;
  int          done_cnt = 0;

  im_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Retire writes and mirror them into an IM model on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (we) begin
        if (sb.size() == 0) chk("spurious_we", 32'(we), 32'd0);
        else begin
          wr_t e;
          e = sb.pop_front();
          chk("waddr", 32'(waddr), 32'(e.a));
          chk("wdata", 32'(wdata), 32'(e.d));
        end
        im[waddr] = wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [9:0] b, input logic [8:0] c);
    start = 1'b1; base_addr = b; word_count = c;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    wait_ready();
    for (int g = 0; g < gap; g++) begin
      chk("gap_ready", 32'(in_ready), 32'd1);
      chk("gap_we", 32'(we), 32'd0);
      tick();
    end
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 4; k++) sb.push_back('{a: tptr + 10'(k), d: w[31-8*k -: 8]});
    tptr += 10'd4;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin tick(); n++; end
    if (n >= 200) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_load(input logic [9:0] b, input logic [8:0] c, input int gap, input bit poke);
    int d0 = done_cnt;
    tptr = b;
    do_start(b, c);
    for (int i = 0; i < int'(c); i++) begin
      send_word(words[i], gap);
      if (poke && i == 0) begin
        // A start while busy must not disturb the current load.
        do_start(10'd64, 9'd1);
      end
    end
    wait_done();
    tick();
    chk("err_clear", 32'(err), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    for (int i = 0; i < int'(c); i++) begin
      int a = int'(b) + 4 * i;
      chk("readback", {im[a], im[a+1], im[a+2], im[a+3]}, words[i]);
    end
  endtask

  task automatic reject(input logic [9:0] b, input logic [8:0] c);
    int d0 = done_cnt;
    do_start(b, c);
    chk("rej_busy", 32'(busy), 32'd1);
    chk("rej_done", 32'(done), 32'd1);
    chk("rej_err", 32'(err), 32'd1);
    tick();
    chk("rej_busy_end", 32'(busy), 32'd0);
    chk("rej_done_end", 32'(done), 32'd0);
    chk("rej_err_sticky", 32'(err), 32'd1);
    chk("rej_pulses", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_data = '0;
    #1;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(we),       32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_err",   32'(err),      32'd0);
    chk("rst_waddr", 32'(waddr),    32'd0);
    chk("rst_wdata", 32'(wdata),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    words[0] = 32'h12345678; words[1] = 32'hDEADBEEF;
    run_load(10'd0, 9'd2, 0, 1'b0);
    run_load(10'd0, 9'd2, 10, 1'b0);

    words[0] = 32'hCAFEF00D;
    run_load(10'd1020, 9'd1, 0, 1'b0);
    reject(10'd1020, 9'd2);
    reject(10'd2, 9'd1);
    words[0] = 32'h0F1E2D3C;
    run_load(10'd0, 9'd1, 0, 1'b0);

    run_load(10'd0, 9'd0, 0, 1'b0);

    words[0] = 32'hA5A55A5A; words[1] = 32'h01020304;
    run_load(10'd32, 9'd2, 0, 1'b1);

    // Reset while byte index 2 is on the write port.
    tptr = 10'd16;
    do_start(10'd16, 9'd1);
    wait_ready();
    in_valid = 1'b1; in_data = 32'hA1B2C3D4;
    for (int k = 0; k < 4; k++) sb.push_back('{a: 10'd16 + 10'(k), d: in_data[31-8*k -: 8]});
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_waddr", 32'(waddr), 32'd18);
    rst_n = 1'b0;
    #1;
    chk("arst_we",    32'(we),       32'd0);
    chk("arst_busy",  32'(busy),     32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_waddr", 32'(waddr),    32'd0);
    chk("arst_left",  32'(sb.size()), 32'd2);
    sb.delete();
    chk("kept_b0", 32'(im[16]), 32'hA1);
    chk("kept_b1", 32'(im[17]), 32'hB2);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    words[0] = 32'h0BADC0DE;
    run_load(10'd16, 9'd1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end
endmodule
